// File: rtl/popeye_dl_pkg.sv
// Shared types and constants for the Popeye download/boot sequencer.
// Holds the FSM state enum, the ioctl index codes and the ROM region map.
package popeye_dl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      SETTLE = 2'd2,
      RUN    = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      REGION_CPU  = 2'd0,
      REGION_SND  = 2'd1,
      REGION_GFX  = 2'd2,
      REGION_PROM = 2'd3
   } region_t;

   localparam logic [7:0] IDX_ROM = 8'd0;
   localparam logic [7:0] IDX_MOD = 8'd1;
   localparam logic [7:0] IDX_DIP = 8'd254;

   // First byte address of each region after CPU; CPU starts at zero.
   localparam logic [24:0] SND_BASE  = 25'h000_8000;
   localparam logic [24:0] GFX_BASE  = 25'h000_A000;
   localparam logic [24:0] PROM_BASE = 25'h001_0000;

endpackage

// File: rtl/popeye_dl_region_dec.sv
// Combinational ROM region decode: maps an ioctl byte address onto the
// core's region tag (CPU / SND / GFX / PROM).
module popeye_dl_region_dec
   import popeye_dl_pkg::*;
(
   input  logic [24:0] addr,
   output region_t     region
);

   // Ordered base compares; anything past the GFX window is PROM.
   always_comb begin
      if (addr < SND_BASE) begin
         region = REGION_CPU;
      end else if (addr < GFX_BASE) begin
         region = REGION_SND;
      end else if (addr < PROM_BASE) begin
         region = REGION_GFX;
      end else begin
         region = REGION_PROM;
      end
   end

endmodule

// File: rtl/popeye_dl_sched.sv
// Download/boot sequencer between the hps_io ioctl stream and the Popeye core.
// Optional feature macro: POPEYE_DL_CHECKSUM_EN adds the dl_checksum output.
module popeye_dl_sched
   import popeye_dl_pkg::*;
#(
   parameter int ADDR_W        = 17,
   parameter int ROM_BYTES     = 'h12000,
   parameter int SETTLE_CYCLES = 16,
   parameter int NUM_SW        = 8
)(
   input  logic                clk_sys,
   input  logic                reset,
   input  logic                user_reset,
   input  logic                ioctl_download,
   input  logic [7:0]          ioctl_index,
   input  logic                ioctl_wr,
   input  logic [24:0]         ioctl_addr,
   input  logic [7:0]          ioctl_dout,
   output logic                dl_wr,
   output logic [ADDR_W-1:0]   dl_addr,
   output logic [7:0]          dl_data,
   output logic [1:0]          dl_region,
   output logic                core_reset,
   output logic                rom_loaded,
   output logic                dl_short,
   output logic [8*NUM_SW-1:0] sw_flat,
   output logic [7:0]          mod
`ifdef POPEYE_DL_CHECKSUM_EN
   ,
   output logic [15:0]         dl_checksum
`endif
);

   localparam int CNT_W = $clog2(ROM_BYTES + 1);
   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] ROM_BYTES_C = CNT_W'(ROM_BYTES);
   localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

   state_t              state_r;
   state_t              state_nxt_s;
   logic                dl_prev_r;
   logic                dl_rise_s;
   logic                rom_start_s;
   logic                rom_acc_s;
   logic                dip_acc_s;
   logic                mod_acc_s;
   logic                load_entry_s;
   logic [CNT_W-1:0]    byte_cnt_r;
   logic [CNT_W-1:0]    byte_cnt_nxt_s;
   logic [SET_W-1:0]    settle_cnt_r;
   region_t             region_s;

   logic                dl_wr_r;
   logic [ADDR_W-1:0]   dl_addr_r;
   logic [7:0]          dl_data_r;
   region_t             dl_region_r;
   logic                core_reset_r;
   logic                core_reset_nxt_s;
   logic                rom_loaded_r;
   logic                rom_loaded_nxt_s;
   logic                dl_short_r;
   logic                dl_short_nxt_s;
   logic [8*NUM_SW-1:0] sw_flat_r;
   logic [7:0]          mod_r;

   popeye_dl_region_dec u_region_dec (
      .addr   (ioctl_addr),
      .region (region_s)
   );

   // Input qualification: download edge detect and per-index write accepts.
   always_comb begin
      dl_rise_s   = ioctl_download & ~dl_prev_r;
      rom_start_s = dl_rise_s & (ioctl_index == IDX_ROM);
      rom_acc_s   = ioctl_wr & ioctl_download & (ioctl_index == IDX_ROM)
                  & (ioctl_addr < 25'(ROM_BYTES)) & (state_r == LOAD);
      dip_acc_s   = ioctl_wr & (ioctl_index == IDX_DIP) & (ioctl_addr[24:3] == 22'd0)
                  & ({29'd0, ioctl_addr[2:0]} < 32'(NUM_SW));
      mod_acc_s   = ioctl_wr & (ioctl_index == IDX_MOD);
      if (rom_acc_s && (byte_cnt_r != ROM_BYTES_C)) begin
         byte_cnt_nxt_s = byte_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         byte_cnt_nxt_s = byte_cnt_r;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic; a fresh index-0 download restarts LOAD from any non-LOAD state.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (rom_start_s) state_nxt_s = LOAD;
            else             state_nxt_s = IDLE;
         end
         LOAD: begin
            if (!ioctl_download) state_nxt_s = SETTLE;
            else                 state_nxt_s = LOAD;
         end
         SETTLE: begin
            if (rom_start_s)                       state_nxt_s = LOAD;
            else if (settle_cnt_r == SETTLE_LAST)  state_nxt_s = RUN;
            else                                   state_nxt_s = SETTLE;
         end
         RUN: begin
            if (rom_start_s) state_nxt_s = LOAD;
            else             state_nxt_s = RUN;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM outputs, computed from the next state so the registered copies line up with it.
   always_comb begin
      load_entry_s = (state_nxt_s == LOAD) && (state_r != LOAD);
      if (load_entry_s) begin
         dl_short_nxt_s = 1'b0;
      end else if ((state_r == LOAD) && (state_nxt_s == SETTLE)) begin
         dl_short_nxt_s = (byte_cnt_nxt_s < ROM_BYTES_C);
      end else begin
         dl_short_nxt_s = dl_short_r;
      end
      case (state_nxt_s)
         RUN: begin
            core_reset_nxt_s = user_reset;
            rom_loaded_nxt_s = ~dl_short_nxt_s;
         end
         default: begin
            core_reset_nxt_s = 1'b1;
            rom_loaded_nxt_s = 1'b0;
         end
      endcase
   end

   // Counters, ROM write port, DIP/mod capture and status registers.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         dl_prev_r    <= ioctl_download;
         byte_cnt_r   <= {CNT_W{1'b0}};
         settle_cnt_r <= {SET_W{1'b0}};
         dl_wr_r      <= 1'b0;
         dl_addr_r    <= {ADDR_W{1'b0}};
         dl_data_r    <= 8'd0;
         dl_region_r  <= REGION_CPU;
         core_reset_r <= 1'b1;
         rom_loaded_r <= 1'b0;
         dl_short_r   <= 1'b0;
         sw_flat_r    <= {(8*NUM_SW){1'b0}};
         mod_r        <= 8'd0;
      end else begin
         dl_prev_r    <= ioctl_download;
         byte_cnt_r   <= load_entry_s ? {CNT_W{1'b0}} : byte_cnt_nxt_s;
         if ((state_r == SETTLE) && (state_nxt_s == SETTLE)) begin
            settle_cnt_r <= settle_cnt_r + {{(SET_W-1){1'b0}}, 1'b1};
         end else begin
            settle_cnt_r <= {SET_W{1'b0}};
         end
         dl_wr_r <= rom_acc_s;
         if (rom_acc_s) begin
            dl_addr_r   <= ioctl_addr[ADDR_W-1:0];
            dl_data_r   <= ioctl_dout;
            dl_region_r <= region_s;
         end
         core_reset_r <= core_reset_nxt_s;
         rom_loaded_r <= rom_loaded_nxt_s;
         dl_short_r   <= dl_short_nxt_s;
         if (dip_acc_s) begin
            sw_flat_r[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
         end
         if (mod_acc_s) begin
            mod_r <= ioctl_dout;
         end
      end
   end

`ifdef POPEYE_DL_CHECKSUM_EN
   logic [15:0] csum_r;

   // Running mod-2^16 sum of accepted ROM bytes, restarted on each new image.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         csum_r <= 16'd0;
      end else if (load_entry_s) begin
         csum_r <= 16'd0;
      end else if (rom_acc_s) begin
         csum_r <= csum_r + {8'd0, ioctl_dout};
      end
   end

   assign dl_checksum = csum_r;
`endif

   assign dl_wr      = dl_wr_r;
   assign dl_addr    = dl_addr_r;
   assign dl_data    = dl_data_r;
   assign dl_region  = dl_region_r;
   assign core_reset = core_reset_r;
   assign rom_loaded = rom_loaded_r;
   assign dl_short   = dl_short_r;
   assign sw_flat    = sw_flat_r;
   assign mod        = mod_r;

endmodule
